etx_channel_arbiter: RTL and testbench



---
 rtl/etx_channel_arbiter.sv | 169 ++++++++++++++++
 tb/tb_etx_channel_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/etx_channel_arbiter.sv
// etx_channel_arbiter: merges the txwr/txrd/txrr emesh channels through 2-entry buffers
// into one registered etx stream. Optional write burst lock: define ETX_ARB_BURST_LOCK_EN.
module etx_channel_arbiter #(
  parameter int PW        = 104,
  parameter int MAX_BURST = 16
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          txwr_access,
  input  logic [PW-1:0] txwr_packet,
  output logic          txwr_wait,
  input  logic          txrd_access,
  input  logic [PW-1:0] txrd_packet,
  output logic          txrd_wait,
  input  logic          txrr_access,
  input  logic [PW-1:0] txrr_packet,
  output logic          txrr_wait,
  output logic          etx_access,
  output logic [PW-1:0] etx_packet,
  input  logic          etx_wait
);
  // last_grant | meaning
  // CH_RR      | rr popped last; search order wr, rd, rr
  // CH_WR      | wr popped last; search order rd, rr, wr (burst lock may keep wr)
  // CH_RD      | rd popped last (reset); search order rr, wr, rd
  typedef enum logic [1:0] {CH_RR = 2'd0, CH_WR = 2'd1, CH_RD = 2'd2} ch_e;

  function automatic logic [1:0] next_ch(input logic [1:0] c);
    return (c == 2'd2) ? 2'd0 : c + 2'd1;
  endfunction

  logic [2:0]    in_acc;
  logic [PW-1:0] in_pkt [3];
  logic [PW-1:0] mem_q [3][2];
  logic [PW-1:0] mem_d [3][2];
  logic [2:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [1:0]    cnt_q [3];
  logic [1:0]    cnt_d [3];
  ch_e           last_grant_q, last_grant_d;
  logic          etx_access_q, etx_access_d;
  logic [PW-1:0] etx_packet_q, etx_packet_d;

  logic          can_load, gnt_valid;
  logic [1:0]    gnt_idx, scan;
  logic [2:0]    nonempty, push, pop;
  logic [PW-1:0] head [3];

`ifdef ETX_ARB_BURST_LOCK_EN
  localparam logic [7:0] MAX_BURST_C = 8'(MAX_BURST);
  logic [7:0]  burst_cnt_q, burst_cnt_d;
  logic [31:0] prev_dst_q, prev_dst_d;
  logic        lock;
`endif

  assign in_acc    = {txrd_access, txwr_access, txrr_access};
  assign in_pkt[0] = txrr_packet;
  assign in_pkt[1] = txwr_packet;
  assign in_pkt[2] = txrd_packet;

  // Waits decode registered counts only, so no input reaches them combinationally.
  assign txrr_wait  = (cnt_q[0] == 2'd2);
  assign txwr_wait  = (cnt_q[1] == 2'd2);
  assign txrd_wait  = (cnt_q[2] == 2'd2);
  assign etx_access = etx_access_q;
  assign etx_packet = etx_packet_q;

  always_comb begin
    mem_d        = mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    etx_access_d = etx_access_q;
    etx_packet_d = etx_packet_q;
    can_load     = !etx_access_q || !etx_wait;
    for (int i = 0; i < 3; i++) begin
      head[i]     = mem_q[i][rd_ptr_q[i]];
      nonempty[i] = (cnt_q[i] != 2'd0);
      push[i]     = in_acc[i] && (cnt_q[i] != 2'd2);
    end

    gnt_valid = 1'b0;
    gnt_idx   = 2'd0;
    scan      = last_grant_q;
    for (int k = 0; k < 3; k++) begin
      scan = next_ch(scan);
      if (!gnt_valid && nonempty[scan]) begin
        gnt_valid = 1'b1;
        gnt_idx   = scan;
      end
    end

`ifdef ETX_ARB_BURST_LOCK_EN
    burst_cnt_d = burst_cnt_q;
    prev_dst_d  = prev_dst_q;
    lock = (last_grant_q == CH_WR) && (burst_cnt_q < MAX_BURST_C) && nonempty[1] &&
           head[1][0] && (head[1][2:1] == 2'b11) && (head[1][39:8] == prev_dst_q + 32'd8);
    if (lock) begin
      gnt_valid = 1'b1;
      gnt_idx   = 2'd1;
    end
`endif

    pop = 3'b000;
    if (can_load && gnt_valid) pop[gnt_idx] = 1'b1;

    for (int i = 0; i < 3; i++) begin
      if (push[i]) begin
        mem_d[i][wr_ptr_q[i]] = in_pkt[i];
        wr_ptr_d[i]           = ~wr_ptr_q[i];
      end
      if (pop[i]) rd_ptr_d[i] = ~rd_ptr_q[i];
      case ({push[i], pop[i]})
        2'b10:   cnt_d[i] = cnt_q[i] + 2'd1;
        2'b01:   cnt_d[i] = cnt_q[i] - 2'd1;
        default: cnt_d[i] = cnt_q[i];
      endcase
    end

    if (can_load) begin
      etx_access_d = gnt_valid;
      if (gnt_valid) begin
        etx_packet_d = head[gnt_idx];
        last_grant_d = ch_e'(gnt_idx);
      end
    end

`ifdef ETX_ARB_BURST_LOCK_EN
    if (pop[1]) begin
      burst_cnt_d = !lock ? 8'd1 : (burst_cnt_q == MAX_BURST_C) ? burst_cnt_q : burst_cnt_q + 8'd1;
      prev_dst_d  = head[1][39:8];
    end else if (can_load && gnt_valid) begin
      burst_cnt_d = 8'd0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      for (int i = 0; i < 3; i++) cnt_q[i] <= 2'd0;
      last_grant_q <= CH_RD;
      etx_access_q <= 1'b0;
      etx_packet_q <= '0;
`ifdef ETX_ARB_BURST_LOCK_EN
      burst_cnt_q  <= 8'd0;
      prev_dst_q   <= 32'd0;
`endif
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      etx_access_q <= etx_access_d;
      etx_packet_q <= etx_packet_d;
`ifdef ETX_ARB_BURST_LOCK_EN
      burst_cnt_q  <= burst_cnt_d;
      prev_dst_q   <= prev_dst_d;
`endif
    end
  end

  // Storage needs no reset: counts and pointers alone decide what is valid.
  always_ff @(posedge clock) begin
    mem_q <= mem_d;
  end

endmodule

// File: tb/tb_etx_channel_arbiter.sv
// tb_etx_channel_arbiter: directed and random stimulus against a queue-based model of
// the arbiter; follows ETX_ARB_BURST_LOCK_EN when defined (MAX_BURST=4).
module tb_etx_channel_arbiter;
  localparam int PW   = 104;
  localparam int MAXB = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          etx_wait;
  logic          acc [3];
  logic [PW-1:0] pkt [3];
  logic          txwr_wait, txrd_wait, txrr_wait, etx_access;
  logic [PW-1:0] etx_packet;
  logic [2:0]    dut_wait;

  etx_channel_arbiter #(.PW(PW), .MAX_BURST(MAXB)) dut (
    .clock(clock), .reset(reset),
    .txwr_access(acc[1]), .txwr_packet(pkt[1]), .txwr_wait(txwr_wait),
    .txrd_access(acc[2]), .txrd_packet(pkt[2]), .txrd_wait(txrd_wait),
    .txrr_access(acc[0]), .txrr_packet(pkt[0]), .txrr_wait(txrr_wait),
    .etx_access(etx_access), .etx_packet(etx_packet), .etx_wait(etx_wait)
  );

  assign dut_wait = {txrd_wait, txwr_wait, txrr_wait};
  always #5 clock = ~clock;

  // channel index: 0 = rr, 1 = wr, 2 = rd
  logic [PW-1:0] src [3][$];
  logic [PW-1:0] mq [3][$];
  logic [PW-1:0] out_log [$];
  bit            accepted [3];
  logic          m_acc;
  logic [PW-1:0] m_pkt;
  int            m_last, m_cnt;
  logic [31:0]   m_prev;
  int            n_assert = 0, n_fail = 0;
  int            p_send = 100;

  task automatic check(string name, logic [PW-1:0] act, logic [PW-1:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] mk(int ch, int seq);
    logic [PW-1:0] p;
    p[31:0]   = $urandom;
    p[63:32]  = $urandom;
    p[95:64]  = $urandom;
    p[103:96] = 8'($urandom);
    p[71:40]  = {8'(ch), 24'(seq)};
    return p;
  endfunction

  function automatic logic [PW-1:0] mkb(int seq, logic [31:0] dst);
    logic [PW-1:0] p;
    p       = mk(1, seq);
    p[0]    = 1'b1;
    p[2:1]  = 2'b11;
    p[39:8] = dst;
    return p;
  endfunction

  function automatic bit idle();
    bit r;
    r = !m_acc;
    for (int i = 0; i < 3; i++)
      if (mq[i].size() != 0 || src[i].size() != 0 || acc[i]) r = 0;
    return r;
  endfunction

  // One clock of the reference: pop from pre-edge contents, then accept pushes.
  task automatic model_step();
    bit can_load, lock, gv, w[3];
    int g, c;
    if (reset) begin
      for (int i = 0; i < 3; i++) begin
        mq[i].delete();
        accepted[i] = 0;
      end
      m_acc = 0; m_pkt = '0; m_last = 2; m_cnt = 0; m_prev = '0;
      return;
    end
    can_load = !m_acc || !etx_wait;
    for (int i = 0; i < 3; i++) begin
      w[i]        = (mq[i].size() == 2);
      accepted[i] = acc[i] && !w[i];
    end
    if (can_load) begin
      lock = 0; gv = 0; g = 0;
`ifdef ETX_ARB_BURST_LOCK_EN
      if (m_last == 1 && m_cnt < MAXB && mq[1].size() > 0) begin
        logic [PW-1:0] h;
        h    = mq[1][0];
        lock = h[0] && (h[2:1] == 2'b11) && (h[39:8] == m_prev + 32'd8);
      end
`endif
      if (lock) begin
        gv = 1; g = 1;
      end else begin
        for (int k = 1; k <= 3; k++) begin
          c = (m_last + k) % 3;
          if (!gv && mq[c].size() > 0) begin gv = 1; g = c; end
        end
      end
      m_acc = gv;
      if (gv) begin
        m_pkt  = mq[g].pop_front();
        m_last = g;
        if (g == 1) begin
          m_cnt  = lock ? m_cnt + 1 : 1;
          m_prev = m_pkt[39:8];
        end else m_cnt = 0;
      end
    end
    for (int i = 0; i < 3; i++) if (accepted[i]) mq[i].push_back(pkt[i]);
  endtask

  task automatic compare();
    check("etx_access", etx_access, m_acc);
    if (m_acc) check("etx_packet", etx_packet, m_pkt);
    check("txrr_wait", dut_wait[0], mq[0].size() == 2);
    check("txwr_wait", dut_wait[1], mq[1].size() == 2);
    check("txrd_wait", dut_wait[2], mq[2].size() == 2);
  endtask

  // Called at the falling edge: drive producers, advance model, clock, compare.
  task automatic tick();
    for (int i = 0; i < 3; i++) begin
      if (acc[i] && !accepted[i]) begin
      end else if (src[i].size() > 0 && $urandom_range(99) < p_send) begin
        acc[i] = 1'b1;
        pkt[i] = src[i].pop_front();
      end else acc[i] = 1'b0;
    end
    model_step();
    if (!reset && etx_access === 1'b1 && etx_wait == 1'b0) out_log.push_back(etx_packet);
    @(posedge clock);
    @(negedge clock);
    compare();
  endtask

  task automatic drain(int budget);
    int b = budget;
    while (!idle() && b > 0) begin tick(); b--; end
    n_assert++;
    if (!idle()) begin
      n_fail++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin acc[i] = 1'b0; src[i].delete(); end
    tick();
    reset = 1'b0;
    etx_wait = 1'b0;
    p_send = 100;
    out_log.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, required finish");
    $fatal(1);
  end

  initial begin
    int n_valid, sent, n_once, hits;
    bit wr_hi;
    int exp_b [10];
    logic [PW-1:0] p_rr0;
    logic [PW-1:0] sent_l [$];
    logic [31:0] bdst;

    // reset / idle with all producers asserting
    reset = 1'b1; etx_wait = 1'b0;
    for (int i = 0; i < 3; i++) begin acc[i] = 1'b1; pkt[i] = mk(i, 100 + i); accepted[i] = 0; end
    repeat (3) tick();
    check("rst_access", etx_access, 0);
    check("rst_packet", etx_packet, 0);
    check("rst_waits", dut_wait, 0);
    reset = 1'b0;
    tick();
    check("post_rst_e0_access", etx_access, 0);
    tick();
    check("post_rst_first", {etx_access, etx_packet[71:64]}, {1'b1, 8'd0});
    drain(50);

    // single channel stream
    do_reset();
    for (int k = 0; k < 10; k++) src[1].push_back(mk(0, k));
    tick();
    check("lat_e0_access", etx_access, 0);
    tick();
    check("lat_e1_access", etx_access, 1);
    check("lat_e1_data", etx_packet[71:40], 0);
    n_valid = 1; wr_hi = 0;
    for (int b = 0; b < 40 && !idle(); b++) begin
      tick();
      if (etx_access) n_valid++;
      if (txwr_wait) wr_hi = 1;
    end
    check("single_valid_cycles", n_valid, 10);
    check("single_wr_wait", wr_hi, 0);
    check("single_count", out_log.size(), 10);
    for (int k = 0; k < out_log.size() && k < 10; k++) check("single_data", out_log[k][71:40], k);

    // round robin from preloaded buffers
    do_reset();
    etx_wait = 1'b1;
    for (int c = 0; c < 3; c++) begin src[c].push_back(mk(c, 0)); src[c].push_back(mk(c, 1)); end
    tick(); tick();
    check("rr_preload_waits", dut_wait, 3'b110);
    etx_wait = 1'b0;
    drain(50);
    check("rr_count", out_log.size(), 6);
    for (int k = 0; k < out_log.size() && k < 6; k++) check("rr_order", out_log[k][71:64], k % 3);

    // backpressure: 20 stalled cycles
    do_reset();
    etx_wait = 1'b1;
    sent_l.delete();
    for (int c = 0; c < 3; c++)
      for (int k = 0; k < 4; k++) begin src[c].push_back(mk(c, k)); sent_l.push_back(src[c][k]); end
    p_rr0 = src[0][0];
    tick(); tick();
    check("stall_hold", etx_packet, p_rr0);
    for (int k = 0; k < 18; k++) begin tick(); check("stall_hold", etx_packet, p_rr0); end
    check("stall_waits", dut_wait, 3'b111);
    etx_wait = 1'b0;
    drain(100);
    n_once = 0;
    foreach (sent_l[j]) begin
      hits = 0;
      foreach (out_log[m]) if (out_log[m] === sent_l[j]) hits++;
      if (hits == 1) n_once++;
    end
    check("stall_exactly_once", n_once, 12);
    check("stall_count", out_log.size(), 12);

    // reset while five packets are buffered
    do_reset();
    etx_wait = 1'b1;
    for (int c = 0; c < 3; c++) begin src[c].push_back(mk(c, 0)); src[c].push_back(mk(c, 1)); end
    repeat (3) tick();
    check("midrst_waits_before", dut_wait, 3'b110);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin acc[i] = 1'b0; src[i].delete(); end
    tick();
    check("midrst_access", etx_access, 0);
    check("midrst_waits", dut_wait, 0);
    reset = 1'b0; etx_wait = 1'b0;
    out_log.delete();
    repeat (10) tick();
    check("midrst_no_output", out_log.size(), 0);

    // write burst versus pending reads
    do_reset();
    for (int k = 0; k < 6; k++) src[1].push_back(mkb(k, 32'h100 + 32'(8 * k)));
    for (int k = 0; k < 4; k++) src[2].push_back(mk(2, k));
`ifdef ETX_ARB_BURST_LOCK_EN
    exp_b = '{1, 1, 1, 1, 2, 1, 1, 2, 2, 2};
`else
    exp_b = '{1, 2, 1, 2, 1, 2, 1, 2, 1, 1};
`endif
    drain(60);
    check("burst_count", out_log.size(), 10);
    for (int k = 0; k < out_log.size() && k < 10; k++) check("burst_order", out_log[k][71:64], exp_b[k]);

    // random traffic with random backpressure
    do_reset();
    p_send = 70; sent = 0; bdst = 32'h1000;
    for (int k = 0; k < 150; k++) begin
      src[0].push_back(mk(0, k));
      src[2].push_back(mk(2, k));
      if ($urandom_range(1) == 1) begin bdst = bdst + 32'd8; src[1].push_back(mkb(k, bdst)); end
      else begin bdst = $urandom; src[1].push_back(mk(1, k)); end
      sent += 3;
    end
    for (int cyc = 0; cyc < 3000 && !idle(); cyc++) begin
      etx_wait = ($urandom_range(99) < 30);
      tick();
    end
    etx_wait = 1'b0;
    drain(200);
    check("random_count", out_log.size(), sent);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
